// File: rtl/s4ga_cfg_tx.sv
// s4ga_cfg_tx: configuration streamer for the s4ga LUT fabric.
// Holds N K-LUT configurations in a register file and serializes them, SI_W
// bits per clock, as the segment stream the s4ga core consumes: per LUT the
// K input-index fields (each zero-padded to whole segments, MSB segment
// first) followed by the padded mask, looping over all N LUTs. The core is
// held in reset (so_rst=1) whenever no sweep stream is live.
//
// State table:
//   IDLE   | not streaming; so=0, so_rst=1, waiting for start
//   STREAM | one segment per clock on so; ends only at a sweep boundary
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   cfg_we      register-file write enable
//   cfg_addr    LUT number to write (out-of-range addresses ignored)
//   cfg_wdata   {idx[0],...,idx[K-1],mask}, idx[0] in the MSBs
//   start       begin streaming (IDLE only)
//   stop        stop at the end of the current sweep
//   so          stream segment to the core (registered)
//   so_rst      core reset (registered)
//   busy        high while streaming
//   lut_idx     LUT whose segment is on so
//   sweep_done  one-cycle pulse with the last segment of LUT N-1
module s4ga_cfg_tx #(
  parameter  int N         = 16,
  parameter  int K         = 4,
  parameter  int SI_W      = 4,
  localparam int N_W       = (N > 1) ? $clog2(N) : 1,
  localparam int IDX_W     = N_W,
  localparam int MASK_W    = 2 ** K,
  localparam int CFG_W     = K * IDX_W + MASK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [N_W-1:0]   cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             stop,
  output logic [SI_W-1:0]  so,
  output logic             so_rst,
  output logic             busy,
  output logic [N_W-1:0]   lut_idx,
  output logic             sweep_done
);

  localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int IDX_EXT   = IDX_SEGS * SI_W;
  localparam int MASK_EXT  = MASK_SEGS * SI_W;
  localparam int SEG_MAX   = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
  localparam int SEG_W     = $clog2(SEG_MAX + 1);
  localparam int K_W       = $clog2(K + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_nx;
  logic [N_W-1:0]   n, n_nx;
  logic [K_W-1:0]   k, k_nx;
  logic [SEG_W-1:0] seg, seg_nx;
  logic             stop_pending, stop_pending_nx;
  logic             issue;
  logic             first_seg;
  logic             at_mask, last_idx_seg, last_mask_seg, sweep_end, sweep_end_nx;
  logic [CFG_W-1:0] mem [N];
  logic [CFG_W-1:0] shadow;
  logic [CFG_W-1:0] src;
  logic [SI_W-1:0]  seg_data;
  logic             addr_ok;

  // Segment ss of field kk (kk==K selects the mask), MSB segment first.
  function automatic logic [SI_W-1:0] seg_of(input logic [CFG_W-1:0] cfg,
                                             input logic [K_W-1:0]   kk,
                                             input logic [SEG_W-1:0] ss);
    logic [IDX_EXT-1:0]  idx_ext;
    logic [MASK_EXT-1:0] mask_ext;
    idx_ext  = IDX_EXT'(IDX_W'(cfg >> (CFG_W - (int'(kk) + 1) * IDX_W)));
    mask_ext = MASK_EXT'(cfg[MASK_W-1:0]);
    if (kk == K_W'(K))
      return SI_W'(mask_ext >> ((MASK_SEGS - 1 - int'(ss)) * SI_W));
    else
      return SI_W'(idx_ext >> ((IDX_SEGS - 1 - int'(ss)) * SI_W));
  endfunction

  generate
    if (N == (1 << N_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (int'(cfg_addr) < N);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (cfg_we && addr_ok) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  assign at_mask       = (k == K_W'(K));
  assign last_idx_seg  = (seg == SEG_W'(IDX_SEGS - 1));
  assign last_mask_seg = (seg == SEG_W'(MASK_SEGS - 1));
  assign sweep_end     = at_mask && last_mask_seg && (n == N_W'(N - 1));

  always_comb begin
    state_nx        = state;
    n_nx            = n;
    k_nx            = k;
    seg_nx          = seg;
    stop_pending_nx = stop_pending;
    issue           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx        = STREAM;
          n_nx            = '0;
          k_nx            = '0;
          seg_nx          = '0;
          stop_pending_nx = 1'b0;
          issue           = 1'b1;
        end
      end
      STREAM: begin
        if (sweep_end && (stop_pending || stop)) begin
          state_nx        = IDLE;
          n_nx            = '0;
          k_nx            = '0;
          seg_nx          = '0;
          stop_pending_nx = 1'b0;
        end else begin
          issue           = 1'b1;
          stop_pending_nx = stop_pending || stop;
          if (at_mask) begin
            if (last_mask_seg) begin
              seg_nx = '0;
              k_nx   = '0;
              n_nx   = (n == N_W'(N - 1)) ? '0 : n + 1'b1;
            end else begin
              seg_nx = seg + 1'b1;
            end
          end else if (last_idx_seg) begin
            seg_nx = '0;
            k_nx   = k + 1'b1;
          end else begin
            seg_nx = seg + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The first segment of a LUT reads the register file directly and the
  // same edge latches that entry into the shadow; later segments of the LUT
  // come from the shadow, so writes during transmission cannot tear it.
  assign first_seg    = (k_nx == '0) && (seg_nx == '0);
  assign src          = first_seg ? mem[n_nx] : shadow;
  assign seg_data     = seg_of(src, k_nx, seg_nx);
  assign sweep_end_nx = (n_nx == N_W'(N - 1)) && (k_nx == K_W'(K)) &&
                        (seg_nx == SEG_W'(MASK_SEGS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n            <= '0;
      k            <= '0;
      seg          <= '0;
      stop_pending <= 1'b0;
      shadow       <= '0;
      so           <= '0;
      so_rst       <= 1'b1;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      n            <= n_nx;
      k            <= k_nx;
      seg          <= seg_nx;
      stop_pending <= stop_pending_nx;
      if (issue && first_seg) shadow <= src;
      so           <= issue ? seg_data : '0;
      so_rst       <= !issue;
      busy         <= issue;
      sweep_done   <= issue && sweep_end_nx;
    end
  end

  // n is cleared whenever the stream ends, so it reads 0 in IDLE.
  assign lut_idx = n;

endmodule

// File: tb/tb_s4ga_cfg_tx.sv
module tb_s4ga_cfg_tx;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // DUT A: N=16, K=4, SI_W=4
  logic        a_we, a_start, a_stop;
  logic [3:0]  a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_so, a_lut;
  logic        a_so_rst, a_busy, a_sd;

  // DUT B: N=64, K=6, SI_W=4
  logic        b_we, b_start, b_stop;
  logic [5:0]  b_addr;
  logic [99:0] b_wdata;
  logic [3:0]  b_so;
  logic [5:0]  b_lut;
  logic        b_so_rst, b_busy, b_sd;

  s4ga_cfg_tx #(.N(16), .K(4), .SI_W(4)) u_a (
    .clk(clk), .rst(rst), .cfg_we(a_we), .cfg_addr(a_addr), .cfg_wdata(a_wdata),
    .start(a_start), .stop(a_stop), .so(a_so), .so_rst(a_so_rst), .busy(a_busy),
    .lut_idx(a_lut), .sweep_done(a_sd)
  );

  s4ga_cfg_tx #(.N(64), .K(6), .SI_W(4)) u_b (
    .clk(clk), .rst(rst), .cfg_we(b_we), .cfg_addr(b_addr), .cfg_wdata(b_wdata),
    .start(b_start), .stop(b_stop), .so(b_so), .so_rst(b_so_rst), .busy(b_busy),
    .lut_idx(b_lut), .sweep_done(b_sd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    bit         dut;
    logic [3:0] so;
    logic       so_rst;
    logic       busy;
    logic [7:0] lut;
    logic       sd;
    string      nm;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int c, input bit d, input logic [3:0] so, input logic so_rst,
                      input logic busy, input logic [7:0] lut, input logic sd, input string nm);
    exp_t e;
    e.c = c; e.dut = d; e.so = so; e.so_rst = so_rst; e.busy = busy;
    e.lut = lut; e.sd = sd; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int c, input bit d, input string nm);
    push(c, d, 4'h0, 1'b1, 1'b0, 8'd0, 1'b0, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation whose cycle has arrived.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] so;
    logic       so_rst, busy, sd;
    logic [7:0] lut;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.c < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.nm, e.c, cyc);
      end else begin
        if (e.dut == 1'b0) begin
          so = a_so; so_rst = a_so_rst; busy = a_busy; lut = {4'b0, a_lut}; sd = a_sd;
        end else begin
          so = b_so; so_rst = b_so_rst; busy = b_busy; lut = {2'b0, b_lut}; sd = b_sd;
        end
        if ({so, so_rst, busy, lut, sd} !== {e.so, e.so_rst, e.busy, e.lut, e.sd}) begin
          errors++;
          $display("FAIL %s @cyc %0d: got so=%h so_rst=%b busy=%b lut=%0d sd=%b, want so=%h so_rst=%b busy=%b lut=%0d sd=%b",
                   e.nm, cyc, so, so_rst, busy, lut, sd, e.so, e.so_rst, e.busy, e.lut, e.sd);
        end
      end
    end
  end

  // Register-file image seen by DUT A in a given sweep of the long run.
  function automatic logic [31:0] img(input int sweep, input int n);
    case (n)
      0:       return 32'h1234CAFE;
      15:      return 32'hFEDC0001;
      3:       return (sweep >= 2) ? 32'hFFFFFFFF : 32'h0;
      5:       return (sweep >= 2) ? 32'hA5A5A5A5 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] nib32(input logic [31:0] w, input int s);
    return 4'(w >> (28 - 4 * s));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0;
    int          w, q, n, s;
    logic [111:0] bexp;
    logic [31:0] w0;

    rst = 1'b1;
    a_we = 0; a_start = 0; a_stop = 0; a_addr = '0; a_wdata = '0;
    b_we = 0; b_start = 0; b_stop = 0; b_addr = '0; b_wdata = '0;
    step(); step(); step();
    push_idle(cyc, 0, "reset_a");
    push_idle(cyc, 1, "reset_b");
    rst = 1'b0;
    step();
    push_idle(cyc, 0, "idle_a");

    // ---------------- DUT B: N64 K6 S4, LUT 0 ----------------
    b_we = 1; b_addr = 6'd0;
    b_wdata = {6'h2A, 6'h01, 6'h02, 6'h03, 6'h04, 6'h3F, 64'h0123456789ABCDEF};
    step();
    b_we = 0; b_start = 1;
    step();
    b_start = 0;
    t0 = cyc;
    bexp = 112'h2A010203043F0123456789ABCDEF;
    for (int i = 0; i < 30; i++) begin
      if (i < 28) push(t0 + i, 1, bexp[111 - 4*i -: 4], 1'b0, 1'b1, 8'd0, 1'b0, "b_lut0_seg");
      else        push(t0 + i, 1, 4'h0, 1'b0, 1'b1, 8'd1, 1'b0, "b_lut1_seg");
    end
    for (int i = 0; i < 30; i++) step();

    // ---------------- DUT A: writes, stop in IDLE ----------------
    a_we = 1; a_addr = 4'd0; a_wdata = 32'h1234CAFE;
    step();
    a_addr = 4'd15; a_wdata = 32'hFEDC0001;
    step();
    a_we = 0; a_stop = 1;
    step();
    a_stop = 0;
    push_idle(cyc, 0, "idle_stop_ignored");

    // start and stop together: start wins, stop must not end the first sweep
    a_start = 1; a_stop = 1;
    step();
    a_start = 0; a_stop = 0;
    t0 = cyc;
    for (int p = 0; p < 392; p++) begin
      if (p < 384) begin
        w = p / 128; q = p % 128; n = q / 8; s = q % 8;
        push(t0 + p, 0, nib32(img(w, n), s), 1'b0, 1'b1, 8'(n), (q == 127), "a_stream");
      end else begin
        push_idle(t0 + p, 0, "a_after_stop");
      end
      if (p == 60)  a_start = 1;
      if (p == 155) begin a_we = 1; a_addr = 4'd3; a_wdata = 32'hFFFFFFFF; end
      if (p == 167) begin a_we = 1; a_addr = 4'd5; a_wdata = 32'hA5A5A5A5; end
      if (p == 275) a_stop = 1;
      if (p == 386) a_stop = 1;
      step();
      a_start = 0; a_we = 0; a_stop = 0;
    end

    // ---------------- restart, then reset mid-LUT ----------------
    a_start = 1;
    step();
    a_start = 0;
    t0 = cyc;
    push(t0 + 0, 0, 4'h1, 1'b0, 1'b1, 8'd0, 1'b0, "a_restart_seg0");
    push(t0 + 1, 0, 4'h2, 1'b0, 1'b1, 8'd0, 1'b0, "a_restart_seg1");
    push(t0 + 2, 0, 4'h3, 1'b0, 1'b1, 8'd0, 1'b0, "a_restart_seg2");
    push_idle(t0 + 3, 0, "a_rst_midlut");
    push_idle(t0 + 3, 1, "b_rst_midstream");
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_we = 1; a_addr = 4'd0; a_wdata = 32'h89AB0123;
    step();
    a_addr = 4'd1; a_wdata = 32'h0000000F;
    step();
    a_we = 0; a_start = 1;
    step();
    a_start = 0;
    t0 = cyc;
    w0 = 32'h89AB0123;
    for (int i = 0; i < 8; i++)
      push(t0 + i, 0, nib32(w0, i), 1'b0, 1'b1, 8'd0, 1'b0, "a_realign_lut0");
    for (int i = 0; i < 8; i++)
      push(t0 + 8 + i, 0, (i == 7) ? 4'hF : 4'h0, 1'b0, 1'b1, 8'd1, 1'b0, "a_realign_lut1");
    push(t0 + 16, 0, 4'h0, 1'b0, 1'b1, 8'd2, 1'b0, "a_realign_lut2");
    for (int i = 0; i < 18; i++) step();

    for (int i = 0; i < 4 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
